// File: rtl/mdio_pkg.sv
// Shared types and constants for the Clause 22 MDIO management responder.
package mdio_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ST1,
      OP,
      ADDR,
      TA,
      RD,
      WR,
      SKIP
   } mdio_state_e;

   localparam logic [1:0] MDIO_OP_READ  = 2'b10;
   localparam logic [1:0] MDIO_OP_WRITE = 2'b01;
   localparam logic [1:0] MDIO_TA_WRITE = 2'b10;
   localparam int         DATA_W        = 16;

endpackage

// File: rtl/mdio_slave_if.sv
// Single-cycle register port between the MDIO responder and a register file.
interface mdio_slave_if;
   import mdio_pkg::*;

   logic [4:0]        reg_addr;
   logic              reg_wr_en;
   logic [DATA_W-1:0] reg_wr_data;
   logic              reg_rd_req;
   logic [DATA_W-1:0] reg_rd_data;

   modport master (
      output reg_addr,
      output reg_wr_en,
      output reg_wr_data,
      output reg_rd_req,
      input  reg_rd_data
   );

   modport slave (
      input  reg_addr,
      input  reg_wr_en,
      input  reg_wr_data,
      input  reg_rd_req,
      output reg_rd_data
   );

endinterface

// File: rtl/mdio_in_sync.sv
// Brings MDC/MDIO into the clk domain and flags the cycle in which MDC rose.
module mdio_in_sync (
   input  logic clk,
   input  logic mdc,
   input  logic mdio_i,
   output logic mdio_s,
   output logic mdc_rise
);

   logic mdc_p0, mdc_p1, mdc_p2;
   logic mdio_p0, mdio_p1;

   // p0/p1: metastability pair; p2: one-clk history of the synced MDC
   always_ff @(posedge clk) begin
      mdc_p0  <= mdc;
      mdc_p1  <= mdc_p0;
      mdc_p2  <= mdc_p1;
      mdio_p0 <= mdio_i;
      mdio_p1 <= mdio_p0;
   end

   assign mdio_s   = mdio_p1;
   assign mdc_rise = mdc_p1 & ~mdc_p2;

endmodule

// File: rtl/mdio_slave.sv
// Clause 22 MDIO responder: decodes frames for PHY_ADDR and drives a register port.
module mdio_slave
   import mdio_pkg::*;
#(
   parameter logic [4:0] PHY_ADDR = 5'd1,
   parameter int         PRE_LEN  = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         mdc,
   input  logic         mdio_i,
   output logic         mdio_o,
   output logic         mdio_t,
   output logic         busy,
   mdio_slave_if.master reg_if
);

   localparam int              PRE_W     = $clog2(PRE_LEN + 1);
   localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(PRE_LEN);
   localparam logic [4:0]      ADDR_LAST = 5'd9;
   localparam logic [4:0]      DATA_LAST = 5'd15;
   localparam logic [4:0]      SKIP_LAST = 5'd17;

   logic              mdio_s, mdc_rise;
   mdio_state_e       state, state_nxt;
   logic [4:0]        bit_cnt;
   logic [PRE_W-1:0]  pre_cnt, pre_cnt_nxt;
   logic              is_read, is_read_nxt;
   logic [DATA_W-1:0] shift_sr, shift_in, rd_buf;
   logic              phy_match, rd_req_d1;
   logic              mdio_o_nxt, mdio_t_nxt, busy_nxt, wr_en_nxt, rd_req_nxt;
   logic [4:0]        reg_addr_nxt;
   logic [DATA_W-1:0] wr_data_nxt;

   mdio_in_sync u_sync (
      .clk      (clk),
      .mdc      (mdc),
      .mdio_i   (mdio_i),
      .mdio_s   (mdio_s),
      .mdc_rise (mdc_rise)
   );

   // One shift register serves OP, address, TA and write-data collection
   assign shift_in  = {shift_sr[DATA_W-2:0], mdio_s};
   assign phy_match = (shift_in[9:5] == PHY_ADDR);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state              <= IDLE;
         bit_cnt            <= '0;
         pre_cnt            <= '0;
         is_read            <= 1'b0;
         mdio_o             <= 1'b1;
         mdio_t             <= 1'b1;
         busy               <= 1'b0;
         reg_if.reg_addr    <= '0;
         reg_if.reg_wr_en   <= 1'b0;
         reg_if.reg_wr_data <= '0;
         reg_if.reg_rd_req  <= 1'b0;
         rd_req_d1          <= 1'b0;
      end else begin
         state   <= state_nxt;
         pre_cnt <= pre_cnt_nxt;
         is_read <= is_read_nxt;
         if (mdc_rise)
            bit_cnt <= (state_nxt != state) ? 5'd0 : bit_cnt + 5'd1;
         mdio_o             <= mdio_o_nxt;
         mdio_t             <= mdio_t_nxt;
         busy               <= busy_nxt;
         reg_if.reg_addr    <= reg_addr_nxt;
         reg_if.reg_wr_en   <= wr_en_nxt;
         reg_if.reg_wr_data <= wr_data_nxt;
         reg_if.reg_rd_req  <= rd_req_nxt;
         rd_req_d1          <= reg_if.reg_rd_req;
      end
   end

   // Read data is captured two clk after the request strobe
   always_ff @(posedge clk) begin
      if (mdc_rise)
         shift_sr <= shift_in;
      if (rd_req_d1)
         rd_buf <= reg_if.reg_rd_data;
   end

   always_comb begin
      state_nxt   = state;
      pre_cnt_nxt = pre_cnt;
      is_read_nxt = is_read;
      if (mdc_rise) begin
         case (state)
            IDLE: begin
               if (mdio_s) begin
                  if (pre_cnt != PRE_MAX)
                     pre_cnt_nxt = pre_cnt + PRE_W'(1);
               end else if (pre_cnt == PRE_MAX) begin
                  state_nxt = ST1;
               end else begin
                  pre_cnt_nxt = '0;
               end
            end
            ST1:  state_nxt = mdio_s ? OP : IDLE;
            OP: begin
               if (bit_cnt == 5'd1) begin
                  if (shift_in[1:0] == MDIO_OP_READ) begin
                     state_nxt   = ADDR;
                     is_read_nxt = 1'b1;
                  end else if (shift_in[1:0] == MDIO_OP_WRITE) begin
                     state_nxt   = ADDR;
                     is_read_nxt = 1'b0;
                  end else begin
                     state_nxt = IDLE;
                  end
               end
            end
            ADDR: if (bit_cnt == ADDR_LAST) state_nxt = phy_match ? TA : SKIP;
            TA: begin
               if (bit_cnt == 5'd1) begin
                  if (is_read)
                     state_nxt = RD;
                  else if (shift_in[1:0] == MDIO_TA_WRITE)
                     state_nxt = WR;
                  else
                     state_nxt = IDLE;
               end
            end
            RD, WR: if (bit_cnt == DATA_LAST) state_nxt = IDLE;
            SKIP:   if (bit_cnt == SKIP_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
         if (state_nxt == IDLE && state != IDLE)
            pre_cnt_nxt = '0;
      end
   end

   always_comb begin
      mdio_o_nxt   = mdio_o;
      mdio_t_nxt   = mdio_t;
      busy_nxt     = (state_nxt != IDLE);
      reg_addr_nxt = reg_if.reg_addr;
      wr_data_nxt  = reg_if.reg_wr_data;
      wr_en_nxt    = 1'b0;
      rd_req_nxt   = 1'b0;
      if (mdc_rise) begin
         case (state)
            ADDR: begin
               if (bit_cnt == ADDR_LAST && phy_match) begin
                  reg_addr_nxt = shift_in[4:0];
                  rd_req_nxt   = is_read;
               end
            end
            TA: begin
               if (is_read) begin
                  mdio_t_nxt = 1'b0;
                  mdio_o_nxt = (bit_cnt == 5'd0) ? 1'b0 : rd_buf[DATA_W-1];
               end
            end
            RD: begin
               if (bit_cnt == DATA_LAST) begin
                  mdio_t_nxt = 1'b1;
                  mdio_o_nxt = 1'b1;
               end else begin
                  mdio_o_nxt = rd_buf[4'd14 - bit_cnt[3:0]];
               end
            end
            WR: begin
               if (bit_cnt == DATA_LAST) begin
                  wr_en_nxt   = 1'b1;
                  wr_data_nxt = shift_in;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mdio_slave.sv
// Directed plus randomized MDIO frames checked against a frame-level reference model.
module tb_mdio_slave;

   localparam logic [4:0] PHY = 5'd1;
   localparam int         PRE = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic mdc = 1'b0;
   logic m_oe = 1'b0;
   logic m_val = 1'b1;
   logic rf_fill = 1'b1;
   logic mdio_line, mdio_o, mdio_t, busy;

   int n_checks = 0;
   int n_pass = 0;
   int n_fail = 0;

   mdio_slave_if rif();

   // Open-drain style line: slave drive wins, else master, else pull-up
   assign mdio_line = !mdio_t ? mdio_o : (m_oe ? m_val : 1'b1);

   mdio_slave #(.PHY_ADDR(PHY), .PRE_LEN(PRE)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .mdc    (mdc),
      .mdio_i (mdio_line),
      .mdio_o (mdio_o),
      .mdio_t (mdio_t),
      .busy   (busy),
      .reg_if (rif)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] init_val(input int i);
      if (i == 2) return 16'h0141;
      return 16'((i * 2971) ^ 16'h5A5A);
   endfunction

   // Register file on the far side of the port; read data is only valid the clk after the request
   logic [15:0] rf [32];
   always @(posedge clk) begin
      if (rf_fill) begin
         for (int i = 0; i < 32; i++) rf[i] <= init_val(i);
      end else if (rif.reg_wr_en) begin
         rf[rif.reg_addr] <= rif.reg_wr_data;
      end
      rif.reg_rd_data <= rif.reg_rd_req ? rf[rif.reg_addr] : 16'($urandom);
   end

   int          wr_cnt = 0, rd_cnt = 0, both_cnt = 0, t_low_cnt = 0;
   logic [4:0]  wr_addr_seen = '0, rd_addr_seen = '0;
   logic [15:0] wr_data_seen = '0;
   always @(negedge clk) begin
      if (rif.reg_wr_en) begin
         wr_cnt       <= wr_cnt + 1;
         wr_addr_seen <= rif.reg_addr;
         wr_data_seen <= rif.reg_wr_data;
      end
      if (rif.reg_rd_req) begin
         rd_cnt       <= rd_cnt + 1;
         rd_addr_seen <= rif.reg_addr;
      end
      if (rif.reg_wr_en && rif.reg_rd_req) both_cnt <= both_cnt + 1;
      if (!mdio_t) t_low_cnt <= t_low_cnt + 1;
   end

   logic [15:0] ref_mem [32];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks = n_checks + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else begin
         n_fail = n_fail + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One MDC period: master value set while MDC low, line sampled just before the rise
   task automatic clk_bit(input logic oe, input logic val, output logic smp, output logic [3:0] tr);
      m_oe  = oe;
      m_val = val;
      repeat (4) @(negedge clk);
      smp = mdio_line;
      mdc = 1'b1;
      tr  = '0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         tr = {tr[2:0], mdio_t};
      end
      mdc = 1'b0;
   endtask

   task automatic send_head(input int pre, input logic [1:0] op, input logic [4:0] phy,
                            input logic [4:0] ra);
      logic s;
      logic [3:0] tr;
      logic [13:0] hdr;
      clk_bit(1'b1, 1'b0, s, tr);
      repeat (pre) clk_bit(1'b1, 1'b1, s, tr);
      hdr = {2'b01, op, phy, ra};
      for (int i = 13; i >= 0; i--) clk_bit(1'b1, hdr[i], s, tr);
   endtask

   task automatic run_frame(input string name, input int pre, input logic [1:0] op,
                            input logic [4:0] phy, input logic [4:0] ra,
                            input logic [1:0] ta, input logic [15:0] wd);
      logic s;
      logic [3:0] tr, ta1_tr;
      logic [15:0] rd;
      logic [1:0] ta_s;
      logic busy_mid;
      int wr0, rd0, tl0;
      bit is_rd, is_wr, acc, hdr_ok;
      is_rd  = (op == 2'b10);
      is_wr  = (op == 2'b01);
      hdr_ok = (pre >= PRE) && (is_rd || is_wr);
      acc    = hdr_ok && (phy == PHY) && (is_rd || ta == 2'b10);
      wr0 = wr_cnt; rd0 = rd_cnt; tl0 = t_low_cnt;
      rd = '0; ta_s = '0; ta1_tr = '0;
      send_head(pre, op, phy, ra);
      busy_mid = busy;
      if (is_rd) begin
         clk_bit(1'b0, 1'b1, ta_s[1], ta1_tr);
         clk_bit(1'b0, 1'b1, ta_s[0], tr);
         for (int i = 15; i >= 0; i--) clk_bit(1'b0, 1'b1, rd[i], tr);
      end else begin
         clk_bit(1'b1, ta[1], s, tr);
         clk_bit(1'b1, ta[0], s, tr);
         for (int i = 15; i >= 0; i--) clk_bit(1'b1, wd[i], s, tr);
      end
      clk_bit(1'b0, 1'b1, s, tr);
      clk_bit(1'b0, 1'b1, s, tr);

      check({name, ".wr_pulses"}, wr_cnt - wr0, (acc && is_wr) ? 1 : 0);
      check({name, ".rd_pulses"}, rd_cnt - rd0, (acc && is_rd) ? 1 : 0);
      check({name, ".busy_mid"}, busy_mid, hdr_ok);
      check({name, ".mdio_t_end"}, mdio_t, 1'b1);
      check({name, ".busy_end"}, busy, 1'b0);
      if (acc && is_wr) begin
         check({name, ".wr_addr"}, wr_addr_seen, ra);
         check({name, ".wr_data"}, wr_data_seen, wd);
         ref_mem[ra] = wd;
      end
      if (acc && is_rd) begin
         check({name, ".rd_addr"}, rd_addr_seen, ra);
         check({name, ".rd_data"}, rd, ref_mem[ra]);
         check({name, ".ta2"}, ta_s[0], 1'b0);
         check({name, ".ta1_latency"}, ta1_tr, 4'b1100);
      end else begin
         check({name, ".no_drive"}, t_low_cnt - tl0, 0);
      end
   endtask

   task automatic abort_read(input logic [4:0] ra);
      logic s;
      logic [3:0] tr;
      int wr0, rd0;
      wr0 = wr_cnt; rd0 = rd_cnt;
      send_head(PRE, 2'b10, PHY, ra);
      clk_bit(1'b0, 1'b1, s, tr);
      clk_bit(1'b0, 1'b1, s, tr);
      for (int i = 15; i >= 9; i--) clk_bit(1'b0, 1'b1, s, tr);
      check("abort.driving", mdio_t, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("abort.mdio_t", mdio_t, 1'b1);
      check("abort.mdio_o", mdio_o, 1'b1);
      check("abort.busy", busy, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("abort.wr_pulses", wr_cnt - wr0, 0);
      check("abort.rd_pulses", rd_cnt - rd0, 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  op, ta;
      logic [4:0]  phy, ra;
      int          pre;
      for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
      rif.reg_rd_data = '0;
      rst_n   = 1'b0;
      rf_fill = 1'b1;
      repeat (4) @(negedge clk);
      rf_fill = 1'b0;
      check("rst.mdio_o", mdio_o, 1'b1);
      check("rst.mdio_t", mdio_t, 1'b1);
      check("rst.busy", busy, 1'b0);
      check("rst.reg_addr", rif.reg_addr, 5'd0);
      check("rst.wr_en", rif.reg_wr_en, 1'b0);
      check("rst.wr_data", rif.reg_wr_data, 16'd0);
      check("rst.rd_req", rif.reg_rd_req, 1'b0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      run_frame("wr04", PRE, 2'b01, PHY, 5'h04, 2'b10, 16'h01E1);
      run_frame("rd02", PRE, 2'b10, PHY, 5'h02, 2'b00, 16'h0000);
      run_frame("mis3", PRE, 2'b01, 5'd3, 5'h05, 2'b10, 16'hBEEF);
      run_frame("mis3rd", PRE, 2'b10, 5'd3, 5'h05, 2'b00, 16'h0000);
      run_frame("after_mis", PRE, 2'b10, PHY, 5'h04, 2'b00, 16'h0000);
      run_frame("short_pre", PRE - 1, 2'b01, PHY, 5'h06, 2'b10, 16'h1234);
      run_frame("bad_ta", PRE, 2'b01, PHY, 5'h07, 2'b11, 16'hCAFE);
      run_frame("after_ta", PRE, 2'b01, PHY, 5'h07, 2'b10, 16'h5555);
      abort_read(5'h07);
      run_frame("after_rst", PRE, 2'b10, PHY, 5'h07, 2'b00, 16'h0000);

      for (int n = 0; n < 16; n++) begin
         case ($urandom_range(0, 5))
            0, 1:    op = 2'b10;
            2, 3:    op = 2'b01;
            4:       op = 2'b00;
            default: op = 2'b11;
         endcase
         phy = ($urandom_range(0, 3) == 0) ? 5'($urandom) : PHY;
         ra  = 5'($urandom);
         ta  = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b10;
         case ($urandom_range(0, 5))
            0:       pre = PRE - 1;
            1:       pre = PRE + 8;
            default: pre = PRE;
         endcase
         run_frame($sformatf("rnd%0d", n), pre, op, phy, ra, ta, 16'($urandom));
      end

      check("never_both_strobes", both_cnt, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mdio_slave.md
# mdio_slave

Clause 22 MDIO management responder: the PHY-side counterpart to the MDIO master that `fpga_core` drives on `phy0_mdc`/`phy0_mdio`. It oversamples MDC/MDIO in the system clock domain and decodes read and write frames addressed to `PHY_ADDR`. Register accesses go out on a simple single-cycle register port. It drives read data back with correct turnaround. It is used as a PHY register model in system benches and as a management-slave endpoint when the FPGA exposes its own registers over MDIO.

## Interface
- `PHY_ADDR`, default 5'd1: PHY address this responder answers to.
- `PRE_LEN`, default 32: minimum number of consecutive preamble 1s required before ST.
- `clk` in 1: system clock; must be ≥ 4× MDC frequency.
- `rst_n` in 1: reset, synchronous, active-low.
- `mdc` in 1: management clock from the master; asynchronous to `clk`.
- `mdio_i` in 1: MDIO pad input.
- `mdio_o` out 1: MDIO pad output value.
- `mdio_t` out 1: tristate control; 1 = released (high-Z), 0 = driving `mdio_o`.
- `reg_addr` out 5: register address of the current access.
- `reg_wr_en` out 1: one-clk write strobe.
- `reg_wr_data` out 16: write data; valid while `reg_wr_en`=1.
- `reg_rd_req` out 1: one-clk read request.
- `reg_rd_data` in 16: read data; sampled exactly 2 clk after `reg_rd_req`.
- `busy` out 1: high from the ST sample to the end of the frame.

## Operation
- `mdc` and `mdio_i` each pass through a 2-FF synchroniser. A rising edge of MDC is a cycle where the synced `mdc` is 1 and its delayed copy is 0. All protocol bits are sampled, and all outputs updated, only in rise cycles.
- Frame format, MSB first: preamble (≥`PRE_LEN` ones), ST=01, OP (10 read, 01 write), PHYAD[4:0], REGAD[4:0], TA, DATA[15:0].
- **IDLE**: `pre_cnt` saturates at `PRE_LEN`. A sampled 1 increments it. A sampled 0 with `pre_cnt`==`PRE_LEN` goes to ST1 and sets `busy`. Any other 0 clears `pre_cnt`.
- **ST1**: a sampled 1 goes to OP. A sampled 0 goes to IDLE with `pre_cnt`=0.
- **OP**: 2 bits. 00 or 11 goes to IDLE with `pre_cnt`=0.
- **ADDR**: 10 bits shifted in. At the 10th bit:
  - if PHYAD==`PHY_ADDR`, load `reg_addr` and go to TA;
  - for a read, also pulse `reg_rd_req` in that cycle;
  - on PHYAD mismatch, go to SKIP.
- **SKIP**: counts 18 bits without driving, then IDLE.
- **TA, read**:
  - At the rise sampling TA bit 1, set `mdio_t`=0 and `mdio_o`=0.
  - At the rise sampling TA bit 2, drive DATA[15].
  - Go to RD.
- **RD**: each rise drives the next data bit. At the rise sampling DATA[0] (16th data rise), set `mdio_t`=1, `mdio_o`=1, then IDLE.
- **TA, write**: both samples are taken. Pattern ≠ 10 aborts to IDLE and no write is issued.
- **WR**: 16 bits shifted in. At the 16th bit, pulse `reg_wr_en` for one clk with `reg_wr_data`, then IDLE.
- Every return to IDLE clears `pre_cnt` and `busy`. Back-to-back frames therefore each need a full preamble.
- Bit counter: 5 bits, cleared on every state entry. No arithmetic beyond the saturating `pre_cnt` and the bit counter.

## Timing
- Reset values: `mdio_o`=1, `mdio_t`=1, `reg_addr`=0, `reg_wr_en`=0, `reg_wr_data`=0, `reg_rd_req`=0, `busy`=0. The state machine resets to IDLE with `pre_cnt`=0.
- Input-to-output latency: `mdio_o`/`mdio_t` change exactly 3 clk after `mdc` goes high (2 sync + 1 output register).
- `reg_rd_data` is latched 2 clk after `reg_rd_req`. The first data bit is driven no earlier than 1 MDC period later, so the data is always stable in time.
- `reg_wr_en` and `reg_rd_req` are never high together. Each is high for exactly one clk per frame.
- Reset asserted mid-frame: on the next clk, all outputs take their reset values and the line is released. The partial frame is lost and no strobe is issued.
- MDIO changing in the same cycle as the MDC rise: the synchronised value is used, with no special handling.

## Structure
- Package `mdio_pkg` holds:
  - state encodings: IDLE, ST1, OP, ADDR, TA, RD, WR, SKIP;
  - opcode constants: `MDIO_OP_READ`=2'b10, `MDIO_OP_WRITE`=2'b01;
  - TA write pattern: 2'b10;
  - data width: 16.
- One sub-module, `mdio_in_sync`. It holds the 2-FF synchronisers for `mdc` and `mdio_i` plus the MDC rise detector. Outputs: `mdio_s`, `mdc_rise`.

## Test plan
- Write, `PHY_ADDR`=1: 32-bit preamble, write reg 0x04 with 0x01E1 → one `reg_wr_en` pulse with `reg_addr`=0x04 and `reg_wr_data`=0x01E1. `mdio_t` stays 1 throughout.
- Read: read reg 0x02 with the model returning 0x0141 → `reg_rd_req` pulses once. The master samples TA2=0, then 0x0141 MSB first. `mdio_t` returns to 1 after bit 0.
- Address mismatch: a frame to PHYAD 3 → no strobes and `mdio_t`=1 throughout. An immediately following frame to PHYAD 1 is decoded correctly.
- Short preamble: 31 ones, then a write → ignored, no strobe.
- Bad TA: write frame with TA=11 → no `reg_wr_en`. The next valid frame succeeds.
- Reset mid-read: `rst_n` low during data bit 8 → next clk `mdio_t`=1, `busy`=0. A subsequent read returns correct data.
